sisc_exec_ctrl: RTL and testbench

SISC_EXEC_CTRL -- requirements
Module: sisc_exec_ctrl

---
 rtl/sisc_exec_ctrl.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_sisc_exec_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_exec_ctrl.sv
// sisc_exec_ctrl: multi-cycle control FSM, ALU, status register and branch
// unit for the SISC processor. Every datapath control output is
// combinational from the current state and the instruction register; the
// only storage is the FSM state, the status flags and the swap temporary.
module sisc_exec_ctrl (
    input  logic        clk,
    input  logic        rst_f,
    input  logic [31:0] ir,
    input  logic [31:0] rsa,
    input  logic [31:0] rsb,
    input  logic [15:0] pc_out,
    output logic [31:0] alu_result,
    output logic [3:0]  stat,
    output logic [15:0] br_addr,
    output logic        pc_rst,
    output logic        pc_write,
    output logic        pc_sel,
    output logic        ir_load,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        dm_we,
    output logic [1:0]  rd_sel,
    output logic [1:0]  swap_reg_sel,
    output logic [1:0]  mm_sel
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned OP_W   = 4;

    // Opcodes (anything not listed here executes as a NOP)
    localparam logic [OP_W-1:0] OP_ALUR = 4'h1;
    localparam logic [OP_W-1:0] OP_ALUI = 4'h2;
    localparam logic [OP_W-1:0] OP_LOD  = 4'h3;
    localparam logic [OP_W-1:0] OP_STR  = 4'h4;
    localparam logic [OP_W-1:0] OP_SWP  = 4'h5;
    localparam logic [OP_W-1:0] OP_BRA  = 4'h6;
    localparam logic [OP_W-1:0] OP_BRR  = 4'h7;
    localparam logic [OP_W-1:0] OP_BNE  = 4'h8;
    localparam logic [OP_W-1:0] OP_BNR  = 4'h9;
    localparam logic [OP_W-1:0] OP_HLT  = 4'hF;

    // ALU function select carried in the mm field
    localparam logic [3:0] FN_ADD = 4'h0;
    localparam logic [3:0] FN_SUB = 4'h1;
    localparam logic [3:0] FN_AND = 4'h2;
    localparam logic [3:0] FN_OR  = 4'h3;
    localparam logic [3:0] FN_XOR = 4'h4;
    localparam logic [3:0] FN_NOT = 4'h5;
    localparam logic [3:0] FN_SHL = 4'h6;
    localparam logic [3:0] FN_SHR = 4'h7;

    typedef enum logic [3:0] {
        START0,
        START1,
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB,
        WB2,
        HALT
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_stat;
    logic [DATA_W-1:0]   r_temp;

    logic [OP_W-1:0]     w_opcode;
    logic [3:0]          w_mm;
    logic [ADDR_W-1:0]   w_imm;
    logic [DATA_W-1:0]   w_imm_sext;
    logic                w_is_alu_r;
    logic                w_is_alu_i;
    logic                w_is_alu;
    logic                w_is_lod;
    logic                w_is_str;
    logic                w_is_swp;
    logic                w_is_br_pos;
    logic                w_is_br_neg;
    logic                w_is_br_rel;
    logic                w_br_cond;
    logic                w_br_taken;
    logic [1:0]          w_mm_sel;

    logic [DATA_W-1:0]   w_alu_b;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_flag_c;
    logic                w_flag_v;
    logic [3:0]          w_flags;
    logic [DATA_W-1:0]   w_mem_addr;
    logic                w_ir_unused;

    // Instruction field extraction and opcode class decode
    assign w_opcode    = ir[31:28];
    assign w_mm        = ir[27:24];
    assign w_imm       = ir[15:0];
    assign w_imm_sext  = {{(DATA_W-ADDR_W){w_imm[ADDR_W-1]}}, w_imm};
    assign w_ir_unused = ^ir[23:16];

    assign w_is_alu_r  = (w_opcode == OP_ALUR);
    assign w_is_alu_i  = (w_opcode == OP_ALUI);
    assign w_is_alu    = w_is_alu_r | w_is_alu_i;
    assign w_is_lod    = (w_opcode == OP_LOD);
    assign w_is_str    = (w_opcode == OP_STR);
    assign w_is_swp    = (w_opcode == OP_SWP);
    assign w_is_br_pos = (w_opcode == OP_BRA) | (w_opcode == OP_BRR);
    assign w_is_br_neg = (w_opcode == OP_BNE) | (w_opcode == OP_BNR);
    assign w_is_br_rel = (w_opcode == OP_BRR) | (w_opcode == OP_BNR);

    // Branch target and condition against the stored flags
    assign br_addr    = w_is_br_rel ? (pc_out + w_imm) : w_imm;
    assign w_br_cond  = |(w_mm & r_stat);
    assign w_br_taken = (w_is_br_pos & w_br_cond) | (w_is_br_neg & ~w_br_cond);

    // Memory address source for LOD/STR
    assign w_mm_sel = (w_mm == 4'h0) ? 2'b01 :
                      (w_mm == 4'h1) ? 2'b00 : 2'b10;

    // ALU operand B and shared adders
    assign w_alu_b    = w_is_alu_i ? w_imm_sext : rsb;
    assign w_sum      = {1'b0, rsa} + {1'b0, w_alu_b};
    assign w_diff     = {1'b0, rsa} + {1'b0, ~w_alu_b} + (DATA_W+1)'(1);
    assign w_mem_addr = rsa + w_imm_sext;

    // ALU function and carry/overflow generation
    always_comb begin
        w_alu_res = '0;
        w_flag_c  = 1'b0;
        w_flag_v  = 1'b0;
        case (w_mm)
            FN_ADD: begin
                w_alu_res = w_sum[DATA_W-1:0];
                w_flag_c  = w_sum[DATA_W];
                w_flag_v  = (rsa[DATA_W-1] == w_alu_b[DATA_W-1]) &&
                            (w_sum[DATA_W-1] != rsa[DATA_W-1]);
            end
            FN_SUB: begin
                w_alu_res = w_diff[DATA_W-1:0];
                w_flag_c  = w_diff[DATA_W];
                w_flag_v  = (rsa[DATA_W-1] != w_alu_b[DATA_W-1]) &&
                            (w_diff[DATA_W-1] != rsa[DATA_W-1]);
            end
            FN_AND: w_alu_res = rsa & w_alu_b;
            FN_OR:  w_alu_res = rsa | w_alu_b;
            FN_XOR: w_alu_res = rsa ^ w_alu_b;
            FN_NOT: w_alu_res = ~rsa;
            FN_SHL: begin
                w_alu_res = {rsa[DATA_W-2:0], 1'b0};
                w_flag_c  = rsa[DATA_W-1];
            end
            FN_SHR: begin
                w_alu_res = {1'b0, rsa[DATA_W-1:1]};
                w_flag_c  = rsa[0];
            end
            default: w_alu_res = '0;
        endcase
    end

    assign w_flags = {w_flag_c, w_alu_res[DATA_W-1], w_flag_v, (w_alu_res == '0)};

    // Result bus: ALU, address sum for loads/stores, swap pass-through
    always_comb begin
        alu_result = w_alu_res;
        if (w_is_lod || w_is_str) begin
            alu_result = w_mem_addr;
        end
        if (r_state == WB && w_is_swp) begin
            alu_result = rsb;
        end
        if (r_state == WB2) begin
            alu_result = r_temp;
        end
    end

    assign stat = r_stat;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst_f) begin
            r_state <= START0;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Status flags load on ALU execute; swap temp captures Rs data on execute
    always_ff @(posedge clk) begin
        if (rst_f) begin
            r_stat <= 4'h0;
            r_temp <= '0;
        end else if (r_state == EXECUTE) begin
            if (w_is_alu) begin
                r_stat <= w_flags;
            end
            if (w_is_swp) begin
                r_temp <= rsa;
            end
        end
    end

    // Next-state and control output decode
    always_comb begin
        w_next_state = r_state;
        pc_rst       = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;
        ir_load      = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 1'b0;
        dm_we        = 1'b0;
        rd_sel       = 2'b00;
        swap_reg_sel = 2'b00;
        mm_sel       = 2'b00;

        if (r_state == DECODE || r_state == EXECUTE || r_state == MEM ||
            r_state == WB || r_state == WB2) begin
            if (w_is_alu_r || w_is_swp) begin
                rd_sel = 2'b01;
            end
            if (w_is_lod || w_is_str) begin
                mm_sel = w_mm_sel;
            end
        end

        case (r_state)
            START0: begin
                pc_rst       = 1'b1;
                w_next_state = START1;
            end
            START1: w_next_state = FETCH;
            FETCH: begin
                ir_load      = 1'b1;
                pc_write     = 1'b1;
                w_next_state = DECODE;
            end
            DECODE: begin
                w_next_state = (w_opcode == OP_HLT) ? HALT : EXECUTE;
            end
            EXECUTE: begin
                if (w_br_taken) begin
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                end
                if (w_is_alu || w_is_swp) begin
                    w_next_state = WB;
                end else if (w_is_lod || w_is_str) begin
                    w_next_state = MEM;
                end else begin
                    w_next_state = FETCH;
                end
            end
            MEM: begin
                dm_we        = w_is_str;
                w_next_state = w_is_lod ? WB : FETCH;
            end
            WB: begin
                rf_we = 1'b1;
                if (w_is_lod) begin
                    wb_sel = 1'b0;
                end else begin
                    wb_sel = 1'b1;
                end
                if (w_is_swp) begin
                    swap_reg_sel = 2'b10;
                    w_next_state = WB2;
                end else begin
                    w_next_state = FETCH;
                end
            end
            WB2: begin
                rf_we        = 1'b1;
                wb_sel       = 1'b1;
                swap_reg_sel = 2'b01;
                w_next_state = FETCH;
            end
            HALT: w_next_state = HALT;
            default: w_next_state = START0;
        endcase
    end

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// tb_sisc_exec_ctrl: directed + randomized instruction stream against an
// instruction-level reference model of the execution controller.
module tb_sisc_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_f;
    logic [31:0] ir;
    logic [31:0] rsa;
    logic [31:0] rsb;
    logic [15:0] pc_out;
    logic [31:0] alu_result;
    logic [3:0]  stat;
    logic [15:0] br_addr;
    logic        pc_rst, pc_write, pc_sel, ir_load, rf_we, wb_sel, dm_we;
    logic [1:0]  rd_sel, swap_reg_sel, mm_sel;
    logic [10:0] ctrl_obs;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  m_stat   = 4'h0;

    localparam logic [10:0] CTRL_START0 = 11'b100_0000_0000;

    sisc_exec_ctrl dut (
        .clk          (clk),
        .rst_f        (rst_f),
        .ir           (ir),
        .rsa          (rsa),
        .rsb          (rsb),
        .pc_out       (pc_out),
        .alu_result   (alu_result),
        .stat         (stat),
        .br_addr      (br_addr),
        .pc_rst       (pc_rst),
        .pc_write     (pc_write),
        .pc_sel       (pc_sel),
        .ir_load      (ir_load),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .dm_we        (dm_we),
        .rd_sel       (rd_sel),
        .swap_reg_sel (swap_reg_sel),
        .mm_sel       (mm_sel)
    );

    always #5 clk = ~clk;

    assign ctrl_obs = {pc_rst, pc_write, pc_sel, ir_load, rf_we, wb_sel, dm_we,
                       rd_sel, swap_reg_sel};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycles an instruction spends from FETCH to its last state
    function automatic int instr_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h2, 4'h4: return 4;
            4'h3, 4'h5:       return 5;
            default:          return 3;
        endcase
    endfunction

    // Expected controls in the k-th cycle of an instruction (k=0 is FETCH)
    function automatic logic [10:0] exp_ctrl(input logic [3:0] op, input int k, input bit taken);
        bit is_alur = (op == 4'h1);
        bit is_alu  = (op == 4'h1) || (op == 4'h2);
        bit is_lod  = (op == 4'h3);
        bit is_str  = (op == 4'h4);
        bit is_swp  = (op == 4'h5);
        bit is_br   = (op >= 4'h6) && (op <= 4'h9);
        logic pw = 1'b0, ps = 1'b0, il = 1'b0, we = 1'b0, ws = 1'b0, dw = 1'b0;
        logic [1:0] rs = 2'b00, sw = 2'b00;
        if (k == 0) begin pw = 1'b1; il = 1'b1; end
        if (k >= 1 && (is_alur || is_swp)) rs = 2'b01;
        if (k == 2 && is_br && taken) begin pw = 1'b1; ps = 1'b1; end
        if (k == 3 && is_str) dw = 1'b1;
        if ((k == 3 && (is_alu || is_swp)) || (k == 4 && is_lod)) begin
            we = 1'b1;
            ws = is_lod ? 1'b0 : 1'b1;
            sw = is_swp ? 2'b10 : 2'b00;
        end
        if (k == 4 && is_swp) begin we = 1'b1; ws = 1'b1; sw = 2'b01; end
        return {1'b0, pw, ps, il, we, ws, dw, rs, sw};
    endfunction

    // Arithmetic definition of the ALU and its flags {C,N,V,Z}
    task automatic alu_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] fn,
                             output logic [31:0] r, output logic [3:0] f);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint s;
        logic c = 1'b0, v = 1'b0;
        r = 32'h0;
        case (fn)
            4'h0: begin
                r = a + b;
                c = ({32'h0, a} + {32'h0, b}) > 64'h0000_0000_FFFF_FFFF;
                s = sa + sb;
                v = (s != longint'($signed(r)));
            end
            4'h1: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s != longint'($signed(r)));
            end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = ~a;
            4'h6: begin r = a << 1; c = a[31]; end
            4'h7: begin r = a >> 1; c = a[0]; end
            default: r = 32'h0;
        endcase
        f = {c, r[31], v, (r == 32'h0)};
    endtask

    // Run one instruction; entered and left just after the FETCH clock edge
    task automatic run_instr(input logic [3:0] op, input logic [3:0] mm, input logic [15:0] imm,
                             input logic [31:0] a, input logic [31:0] b, input logic [15:0] pc);
        logic [31:0] simm = {{16{imm[15]}}, imm};
        logic [31:0] exp_r;
        logic [3:0]  exp_f;
        logic [15:0] tgt;
        bit          is_alu = (op == 4'h1) || (op == 4'h2);
        bit          is_mem = (op == 4'h3) || (op == 4'h4);
        bit          taken;
        int          len = instr_len(op);
        ir     = {op, mm, 8'($urandom), imm};
        rsa    = a;
        rsb    = b;
        pc_out = pc;
        alu_model(a, (op == 4'h2) ? simm : b, mm, exp_r, exp_f);
        taken = ((op == 4'h6) || (op == 4'h7)) ? ((mm & m_stat) != 4'h0) :
                ((op == 4'h8) || (op == 4'h9)) ? ((mm & m_stat) == 4'h0) : 1'b0;
        tgt   = ((op == 4'h7) || (op == 4'h9)) ? 16'(pc + imm) : imm;
        for (int k = 0; k < len; k++) begin
            #1;
            chk($sformatf("ctrl op%0h k%0d", op, k), 32'(ctrl_obs), 32'(exp_ctrl(op, k, taken)));
            if (k == 0) chk("stat_hold", 32'(stat), 32'(m_stat));
            if (k == 2 && is_alu) chk($sformatf("alu mm%0h", mm), alu_result, exp_r);
            if (k == 2 && is_mem && mm == 4'h1) chk("mem_addr", alu_result, a + simm);
            if (k == 2 && op >= 4'h6 && op <= 4'h9) chk("br_addr", 32'(br_addr), 32'(tgt));
            if (k == 3 && is_mem)
                chk("mm_sel", 32'(mm_sel), (mm == 4'h0) ? 32'h1 : (mm == 4'h1) ? 32'h0 : 32'h2);
            if (k == 3 && is_alu) chk("stat_upd", 32'(stat), 32'(exp_f));
            if (k == 3 && op == 4'h5) chk("swp_wb", alu_result, b);
            if (k == 4 && op == 4'h5) chk("swp_wb2", alu_result, a);
            if (k == 2 && is_alu) m_stat = exp_f;
            @(posedge clk);
            #1;
        end
    endtask

    // Reset for two edges from wherever the FSM is, then walk to FETCH
    task automatic do_reset();
        rst_f = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_ctrl", 32'(ctrl_obs), 32'(CTRL_START0));
            chk("rst_mm_sel", 32'(mm_sel), 32'h0);
            chk("rst_stat", 32'(stat), 32'h0);
        end
        rst_f  = 1'b0;
        m_stat = 4'h0;
        @(posedge clk);
        #1;
        chk("start1_ctrl", 32'(ctrl_obs), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_f  = 1'b1;
        ir     = 32'h0;
        rsa    = 32'h0;
        rsb    = 32'h0;
        pc_out = 16'h0;
        do_reset();

        // Directed: overflow ADD, branch not taken, zero SUB, branch taken, swap
        run_instr(4'h1, 4'h0, 16'h0000, 32'h7FFF_FFFF, 32'h1, 16'h0);
        chk("add_stat", 32'(stat), 32'h6);
        run_instr(4'h7, 4'h1, 16'hFFFE, 32'h0, 32'h0, 16'h0010);
        run_instr(4'h2, 4'h1, 16'h0005, 32'h5, 32'h0, 16'h0);
        chk("sub_stat", 32'(stat), 32'h9);
        run_instr(4'h7, 4'h1, 16'hFFFE, 32'h0, 32'h0, 16'h0010);
        run_instr(4'h5, 4'h0, 16'h0000, 32'hA, 32'hB, 16'h0);
        run_instr(4'h3, 4'h0, 16'h1234, 32'h100, 32'h0, 16'h0);
        run_instr(4'h4, 4'h2, 16'h0010, 32'h200, 32'h0, 16'h0);

        // Randomized instruction stream (no HLT)
        for (int n = 0; n < 150; n++) begin
            logic [3:0]  op;
            logic [3:0]  mm;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 14));
            mm = (op == 4'h1 || op == 4'h2) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_instr(op, mm, 16'($urandom), a, b, 16'($urandom));
        end

        // Reset in the middle of an instruction clears stat
        run_instr(4'h1, 4'h0, 16'h0000, 32'h7FFF_FFFF, 32'h1, 16'h0);
        ir = {4'h1, 4'h1, 24'h0};
        @(posedge clk);
        #1;
        do_reset();

        // HLT parks the FSM with all controls low until reset
        ir = {4'hF, 28'h0};
        #1;
        chk("hlt_fetch", 32'(ctrl_obs), 32'(exp_ctrl(4'hF, 0, 1'b0)));
        @(posedge clk);
        #1;
        chk("hlt_decode", 32'(ctrl_obs), 32'h0);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("halt_ctrl", 32'(ctrl_obs), 32'h0);
            chk("halt_mm_sel", 32'(mm_sel), 32'h0);
        end
        do_reset();
        run_instr(4'h1, 4'h4, 16'h0000, 32'hF0F0_0000, 32'hF0F0_0000, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
